// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART receiver and transmitter: the frame state
// encoding, the default payload width, the frame length and the line levels.
// Ports: none (package).

package uart_pkg;

    // Frame state encoding, shared with the transmitter.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PARITY = 2'd1,
        DATA   = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam int DATA_W_DEFAULT = 7;

    // start + parity + payload + stop, one clk per bit
    localparam int FRAME_LEN = DATA_W_DEFAULT + 3;

    localparam logic IDLE_LVL  = 1'b0;
    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;

endpackage : uart_pkg

// File: rtl/uart_rx_hold.sv
// uart_rx_hold
// Output hold register for the UART receiver. It holds one received frame
// for the consumer, reports frames dropped under backpressure, and counts
// the frames it has accepted.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load            a good frame is complete this cycle
//   load_data       payload of that frame
//   load_perr       parity flag of that frame
//   ready           consumer accepts data_out this cycle
//   data_out        held payload
//   valid           data_out/parity_err hold an unread frame
//   parity_err      parity flag of the held frame
//   overrun         sticky: a good frame was dropped
//   frame_cnt       number of frames loaded, wraps at 256

module uart_rx_hold
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_perr,
    input  logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              overrun,
    output logic [7:0]        frame_cnt
);

    // Handshake: valid, data_out and parity_err stay stable until a cycle
    // with valid & ready. That cycle consumes the frame, and valid drops on
    // the following edge unless a new frame loads on the same edge. A new
    // frame arriving while an unconsumed frame is held (valid & !ready) is
    // dropped and sets overrun.
    logic space;
    assign space = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            frame_cnt  <= 8'd0;
        end else if (load) begin
            if (space) begin
                data_out   <= load_data;
                parity_err <= load_perr;
                valid      <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule : uart_rx_hold

// File: rtl/uart_rx.sv
// uart_rx
// Serial receiver, one line bit per clk, no oversampling. Frame format:
// start (1), parity bit, DATA_W data bits LSB first, stop (0); idle is 0.
// The deserializer FSM lives here; completed good frames go to uart_rx_hold.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bit_in       serial line
//   ready        consumer accepts data_out
//   data_out     received payload
//   valid        data_out/parity_err hold an unread frame
//   parity_err   parity mismatch on the held frame
//   frame_err    one-cycle pulse after a bad stop bit
//   overrun      sticky; a good frame was dropped
//   frame_cnt    count of frames loaded into the hold register

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic [7:0]        frame_cnt
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_e         state;   // current receiver state, observable for checkers
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] payload;
    logic              rx_par;

    logic frame_good;
    logic frame_perr;

    // The hold register loads on the edge that ends the STOP cycle, so the
    // good-frame strobe is decoded from the current state and line bit.
    assign frame_good = (state == STOP) && (bit_in == STOP_LVL);
    // Received parity bit should equal the XOR of the data bits.
    assign frame_perr = rx_par ^ (^payload);

    // Deserializer. Independent of ready: reception never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            payload   <= '0;
            rx_par    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bit_in == START_LVL) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    rx_par <= bit_in;
                    index  <= '0;
                    state  <= DATA;
                end
                DATA: begin
                    payload[index] <= bit_in;
                    if (index == LAST_IDX) begin
                        index <= '0;
                        state <= STOP;
                    end else begin
                        index <= index + IDX_W'(1);
                    end
                end
                STOP: begin
                    // A bad stop bit is dropped and never taken as a new
                    // start bit: always return to IDLE from here.
                    if (bit_in != STOP_LVL) begin
                        frame_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_rx_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (frame_good),
        .load_data  (payload),
        .load_perr  (frame_perr),
        .ready      (ready),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed bench for uart_rx: a table of single frames plus hand-written
// sequences for timing, framing error, backpressure, reset and counter wrap.

module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       bit_in;
    logic       ready;
    logic [6:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .ready      (ready),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        bit_in = 1'b0;
        ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Sends start, parity, 7 data bits LSB first, stop. Returns 1 time unit
    // after the edge that ends the stop cycle. rdy_stop raises ready during
    // the stop cycle only.
    task automatic send_frame(input logic [6:0] d, input logic p, input logic stop,
                              input logic rdy_stop);
        logic saved;
        bit_in = 1'b1;
        step();
        bit_in = p;
        step();
        for (int i = 0; i < 7; i++) begin
            bit_in = d[i];
            step();
        end
        saved  = ready;
        if (rdy_stop) ready = 1'b1;
        bit_in = stop;
        step();
        ready  = saved;
        bit_in = 1'b0;
    endtask

    // scoreboard check
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0] data;
        logic       par;
        logic       stop;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_ferr;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic seen_bad;
        logic [6:0] d;

        // data, parity bit, stop bit, valid, parity_err, frame_err, frame_cnt
        vecs[0] = '{7'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[1] = '{7'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
        vecs[2] = '{7'h2A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[3] = '{7'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
        vecs[4] = '{7'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4};
        vecs[5] = '{7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5};

        // reset state
        do_reset();
        chk("rst_valid", valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_cnt", frame_cnt, 0);

        // table: one frame each, ready low during the frame, then drained
        for (int v = 0; v < 6; v++) begin
            ready = 1'b0;
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 1'b0);
            chk($sformatf("vec%0d_valid", v), valid, vecs[v].exp_valid);
            chk($sformatf("vec%0d_ferr", v), frame_err, vecs[v].exp_ferr);
            chk($sformatf("vec%0d_cnt", v), frame_cnt, vecs[v].exp_cnt);
            chk($sformatf("vec%0d_ovr", v), overrun, 0);
            if (vecs[v].exp_valid) begin
                chk($sformatf("vec%0d_data", v), data_out, vecs[v].data);
                chk($sformatf("vec%0d_perr", v), parity_err, vecs[v].exp_perr);
            end
            ready = 1'b1;
            step();
            ready = 1'b0;
            chk($sformatf("vec%0d_drain_valid", v), valid, 0);
            chk($sformatf("vec%0d_drain_ferr", v), frame_err, 0);
        end

        // 0x55 stream: valid low while the stop bit is sampled, high one cycle later
        do_reset();
        bit_in = 1'b1; step();
        bit_in = 1'b0; step();
        d = 7'h55;
        for (int i = 0; i < 7; i++) begin
            bit_in = d[i];
            step();
        end
        bit_in = 1'b0;
        chk("s55_valid_at_stop", valid, 0);
        step();
        chk("s55_valid", valid, 1);
        chk("s55_data", data_out, 7'h55);
        chk("s55_perr", parity_err, 0);
        chk("s55_cnt", frame_cnt, 1);

        // bad stop bit: one-cycle frame_err, no restart, then 0x11 received
        do_reset();
        send_frame(7'h2A, 1'b1, 1'b1, 1'b0);
        chk("ferr_pulse", frame_err, 1);
        chk("ferr_valid", valid, 0);
        chk("ferr_cnt", frame_cnt, 0);
        step();
        chk("ferr_one_cycle", frame_err, 0);
        seen_bad = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (valid || frame_err) seen_bad = 1'b1;
        end
        chk("ferr_no_restart", seen_bad, 0);
        chk("ferr_cnt_after", frame_cnt, 0);
        send_frame(7'h11, 1'b0, 1'b0, 1'b0);
        chk("ferr_next_valid", valid, 1);
        chk("ferr_next_data", data_out, 7'h11);
        chk("ferr_next_perr", parity_err, 0);
        chk("ferr_next_cnt", frame_cnt, 1);

        // back-to-back frames, ready low throughout: second is dropped
        do_reset();
        send_frame(7'h12, 1'b0, 1'b0, 1'b0);
        chk("ovr_first_valid", valid, 1);
        chk("ovr_first_data", data_out, 7'h12);
        send_frame(7'h34, 1'b1, 1'b0, 1'b0);
        chk("ovr_data_kept", data_out, 7'h12);
        chk("ovr_flag", overrun, 1);
        chk("ovr_cnt", frame_cnt, 1);
        chk("ovr_valid", valid, 1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("ovr_drain_valid", valid, 0);
        step();
        chk("ovr_sticky", overrun, 1);

        // new frame completes on the same cycle the held frame is accepted
        do_reset();
        send_frame(7'h12, 1'b0, 1'b0, 1'b0);
        send_frame(7'h34, 1'b1, 1'b0, 1'b1);
        chk("same_valid", valid, 1);
        chk("same_data", data_out, 7'h34);
        chk("same_ovr", overrun, 0);
        chk("same_cnt", frame_cnt, 2);

        // reset on the 4th data bit, with a frame held and overrun set
        do_reset();
        send_frame(7'h12, 1'b0, 1'b0, 1'b0);
        send_frame(7'h34, 1'b1, 1'b0, 1'b0);
        d = 7'h0F;
        bit_in = 1'b1; step();
        bit_in = 1'b0; step();
        for (int i = 0; i < 3; i++) begin
            bit_in = d[i];
            step();
        end
        bit_in = d[3];
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        chk("mrst_valid", valid, 0);
        chk("mrst_data", data_out, 0);
        chk("mrst_ovr", overrun, 0);
        chk("mrst_cnt", frame_cnt, 0);
        chk("mrst_ferr", frame_err, 0);
        seen_bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bit_in = 1'b0;
            step();
            if (valid || frame_err) seen_bad = 1'b1;
        end
        chk("mrst_quiet", seen_bad, 0);
        send_frame(7'h2A, 1'b1, 1'b0, 1'b0);
        chk("mrst_resume_data", data_out, 7'h2A);
        chk("mrst_resume_cnt", frame_cnt, 1);

        // frame_cnt wraps 255 -> 0, ready high throughout
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            d = 7'(i);
            send_frame(d, ^d, 1'b0, 1'b0);
            if (i == 254) chk("wrap_cnt_255", frame_cnt, 255);
        end
        chk("wrap_cnt_0", frame_cnt, 0);
        chk("wrap_valid", valid, 1);
        chk("wrap_data", data_out, 7'h7F);
        chk("wrap_ovr", overrun, 0);
        ready = 1'b0;

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_rx
